fare_backend_arbiter: RTL and testbench
=======================================

Name: fare_backend_arbiter

Overview:
Shares one fare backend (card validity and balance lookup) between NUM_GATES gate controllers at one station.
- Each gate FSM raises a request with its card ID.
- The arbiter picks one gate round-robin, runs a single request/response handshake with the backend, and returns the result to the winning gate only.
- A timeout guards against a silent backend.

Parameters:
NUM_GATES, 4, number of gate controllers sharing the backend (2..16)
ID_W, 16, card ID width
TIMEOUT_CYCLES, 15, max cycles waiting in WAIT_RESP before a synthetic failure response

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
gate_req  in  NUM_GATES  per-gate lookup request; held high until served
gate_card_id  in  NUM_GATES*ID_W  packed card IDs; gate i occupies bits [i*ID_W +: ID_W]
gate_grant  out  NUM_GATES  one-hot; high for the granted gate from ISSUE through RESPOND
gate_resp_valid  out  NUM_GATES  one-hot single-cycle result strobe
gate_card_active  out  1  result: card exists and is active; valid with gate_resp_valid
gate_fund_enough  out  1  result: balance sufficient; valid with gate_resp_valid
gate_timeout  out  1  result came from the timeout path; valid with gate_resp_valid
be_valid  out  1  backend request valid
be_card_id  out  ID_W  card ID of the granted gate
be_ready  in  1  backend accepts the request when be_valid && be_ready
be_resp_valid  in  1  backend result strobe
be_card_active  in  1  backend result
be_fund_enough  in  1  backend result

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; RR pointer 0; timeout counter 0; last_winner invalid.

States:
- IDLE: eff_req = gate_req with the last winner masked, but only in the first IDLE cycle after RESPOND. If eff_req != 0, choose the first set bit at or after the RR pointer (wrapping), latch winner index and card ID, then go to ISSUE. Otherwise stay.
- ISSUE: be_valid=1, be_card_id=latched ID. On be_valid&&be_ready go to WAIT_RESP and clear the counter. The card ID is latched, so it is stable even if the gate changes it.
- WAIT_RESP: be_valid=0; counter increments each cycle.
  - On be_resp_valid: capture results, go to RESPOND.
  - Else if counter==TIMEOUT_CYCLES-1: capture card_active=0, fund_enough=0, timeout=1, go to RESPOND.
  - be_resp_valid in the same cycle as expiry: the backend response wins and timeout=0.
- RESPOND: for exactly one cycle, gate_resp_valid[winner]=1 and result outputs driven. Then go to IDLE; RR pointer = (winner+1) mod NUM_GATES; last_winner = winner.

Timing and rules:
- gate_grant is one-hot on winner during ISSUE, WAIT_RESP and RESPOND; 0 in IDLE.
- Result outputs are 0 whenever gate_resp_valid is all-zero.
- Minimum latency: req sampled in cycle 0 (IDLE) -> ISSUE in cycle 1 (be_ready=1) -> WAIT_RESP in cycle 2 (resp=1) -> RESPOND in cycle 3, so gate_resp_valid is seen in cycle 3.
- Winner drops gate_req mid-transaction: the transaction still completes and the response is still strobed. The gate ignores it.
- be_resp_valid outside WAIT_RESP is ignored.
- be_ready outside ISSUE is ignored.
- Reset mid-transaction: return to IDLE next cycle, be_valid drops, no response is strobed.
- Pointer arithmetic wraps modulo NUM_GATES; NUM_GATES need not be a power of two.

Decomposition:
- Package fare_arb_pkg: state enum (IDLE, ISSUE, WAIT_RESP, RESPOND), fare_result_t struct {card_active, fund_enough, timeout}, and a clog2-based index width helper.
- One combinational sub-module rr_picker: inputs req vector and pointer; outputs found and index.
- The FSM, latches and counter live in fare_backend_arbiter.

Test Plan:
- Single request: gate 2 req, be_ready=1 in cycle 1, resp(active=1, fund=1) in cycle 2 -> gate_resp_valid=4'b0100 in cycle 3, active=1, fund=1, timeout=0, be_card_id=gate 2 ID.
- Fairness: all 4 gates hold req, backend always ready and responding 1 cycle later -> serve order 0,1,2,3,0. No gate is served twice before all others are served once.
- Timeout: gate 1 req, be_ready=1, no be_resp_valid -> RESPOND after exactly 15 WAIT_RESP cycles with active=0, fund=0, timeout=1.
- Timeout race: be_resp_valid (active=1, fund=0) in the final WAIT_RESP cycle -> timeout=0, active=1, fund=0.
- Backpressure and ID stability: be_ready low for 5 cycles while the gate changes its card_id -> be_valid stays 1, be_card_id holds the latched value, and handshake occurs on the first be_ready=1.
- Reset mid-WAIT_RESP: assert rst for 1 cycle -> all outputs 0 next cycle; a late be_resp_valid is ignored; a new req is served from pointer 0.

Source files
------------

// File: rtl/fare_arb_pkg.sv
// Shared types and helpers for the fare backend arbiter.
// Used by the round-robin picker and the arbiter top.
package fare_arb_pkg;

    typedef logic [1:0] fare_state_t;

    localparam fare_state_t IDLE      = 2'd0;
    localparam fare_state_t ISSUE     = 2'd1;
    localparam fare_state_t WAIT_RESP = 2'd2;
    localparam fare_state_t RESPOND   = 2'd3;

    typedef struct packed {
        logic card_active;
        logic fund_enough;
        logic timeout;
    } fare_result_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first set request bit at or after ptr, wrapping.
// Handles request vectors whose length is not a power of two.
module rr_picker
    import fare_arb_pkg::*;
#(
    parameter int unsigned NUM_GATES = 4,
    localparam int unsigned IW = idx_w(NUM_GATES)
) (
    input  logic [NUM_GATES-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic                 found,
    output logic [IW-1:0]        index
);

    logic [NUM_GATES-1:0] req_hi;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest.
    always_comb begin
        req_hi = '0;
        found  = |req;
        index  = '0;
        for (int j = 0; j < int'(NUM_GATES); j++) begin
            req_hi[j] = req[j] && (j >= int'(ptr));
        end
        for (int j = int'(NUM_GATES) - 1; j >= 0; j--) begin
            if (req[j]) index = IW'(j);
        end
        for (int j = int'(NUM_GATES) - 1; j >= 0; j--) begin
            if (req_hi[j]) index = IW'(j);
        end
    end

endmodule

// File: rtl/fare_backend_arbiter.sv
// Shares one fare backend among several gate controllers: round-robin pick,
// one request/response handshake, result strobed back to the winner only.
module fare_backend_arbiter
    import fare_arb_pkg::*;
#(
    parameter int unsigned NUM_GATES      = 4,
    parameter int unsigned ID_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_GATES-1:0]      gate_req,
    input  logic [NUM_GATES*ID_W-1:0] gate_card_id,
    output logic [NUM_GATES-1:0]      gate_grant,
    output logic [NUM_GATES-1:0]      gate_resp_valid,
    output logic                      gate_card_active,
    output logic                      gate_fund_enough,
    output logic                      gate_timeout,
    output logic                      be_valid,
    output logic [ID_W-1:0]           be_card_id,
    input  logic                      be_ready,
    input  logic                      be_resp_valid,
    input  logic                      be_card_active,
    input  logic                      be_fund_enough
);

    localparam int unsigned IW = idx_w(NUM_GATES);
    localparam int unsigned CW = idx_w(TIMEOUT_CYCLES);

    fare_state_t          state, state_d;
    logic [IW-1:0]        ptr, ptr_d;
    logic [IW-1:0]        winner, winner_d;
    logic [IW-1:0]        last_winner, last_winner_d;
    logic                 last_valid, last_valid_d;
    logic                 first_idle, first_idle_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [ID_W-1:0]      id_q, id_d;

    logic [NUM_GATES-1:0] eff_req;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;

    logic [NUM_GATES-1:0] grant_d;
    logic [NUM_GATES-1:0] resp_valid_d;
    logic                 be_valid_d;
    logic [ID_W-1:0]      be_card_id_d;
    fare_result_t         res_q, res_d;

    logic [ID_W-1:0]      card_ids [NUM_GATES];

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_ids
        assign card_ids[g] = gate_card_id[g*ID_W +: ID_W];
    end

    // The gate just served sits out the first IDLE cycle so it cannot re-win immediately.
    always_comb begin
        eff_req = gate_req;
        if (first_idle && last_valid) begin
            eff_req[last_winner] = 1'b0;
        end
    end

    rr_picker #(
        .NUM_GATES (NUM_GATES)
    ) u_picker (
        .req   (eff_req),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        winner_d      = winner;
        last_winner_d = last_winner;
        last_valid_d  = last_valid;
        first_idle_d  = 1'b0;
        cnt_d         = cnt;
        id_d          = id_q;
        grant_d       = '0;
        resp_valid_d  = '0;
        be_valid_d    = 1'b0;
        be_card_id_d  = '0;
        res_d         = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    winner_d     = pick_idx;
                    id_d         = card_ids[pick_idx];
                    state_d      = ISSUE;
                    grant_d      = NUM_GATES'(1) << pick_idx;
                    be_valid_d   = 1'b1;
                    be_card_id_d = card_ids[pick_idx];
                end
            end
            ISSUE: begin
                grant_d = NUM_GATES'(1) << winner;
                if (be_valid && be_ready) begin
                    state_d = WAIT_RESP;
                    cnt_d   = '0;
                end else begin
                    be_valid_d   = 1'b1;
                    be_card_id_d = id_q;
                end
            end
            WAIT_RESP: begin
                grant_d = NUM_GATES'(1) << winner;
                cnt_d   = cnt + CW'(1);
                // A real response beats expiry in the same cycle.
                if (be_resp_valid) begin
                    res_d.card_active = be_card_active;
                    res_d.fund_enough = be_fund_enough;
                    resp_valid_d      = NUM_GATES'(1) << winner;
                    state_d           = RESPOND;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    res_d.timeout = 1'b1;
                    resp_valid_d  = NUM_GATES'(1) << winner;
                    state_d       = RESPOND;
                end
            end
            RESPOND: begin
                state_d       = IDLE;
                ptr_d         = (winner == IW'(NUM_GATES - 1)) ? '0 : winner + IW'(1);
                last_winner_d = winner;
                last_valid_d  = 1'b1;
                first_idle_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            winner          <= '0;
            last_winner     <= '0;
            last_valid      <= 1'b0;
            first_idle      <= 1'b0;
            cnt             <= '0;
            id_q            <= '0;
            gate_grant      <= '0;
            gate_resp_valid <= '0;
            be_valid        <= 1'b0;
            be_card_id      <= '0;
            res_q           <= '0;
        end else begin
            state           <= state_d;
            ptr             <= ptr_d;
            winner          <= winner_d;
            last_winner     <= last_winner_d;
            last_valid      <= last_valid_d;
            first_idle      <= first_idle_d;
            cnt             <= cnt_d;
            id_q            <= id_d;
            gate_grant      <= grant_d;
            gate_resp_valid <= resp_valid_d;
            be_valid        <= be_valid_d;
            be_card_id      <= be_card_id_d;
            res_q           <= res_d;
        end
    end

    assign gate_card_active = res_q.card_active;
    assign gate_fund_enough = res_q.fund_enough;
    assign gate_timeout     = res_q.timeout;

endmodule

// File: tb/tb_fare_backend_arbiter.sv
// Bench for fare_backend_arbiter: transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed literals.
module tb_fare_backend_arbiter;

    localparam int NG  = 4;
    localparam int IDW = 16;
    localparam int TO  = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NG-1:0]   gate_req;
    logic [NG*IDW-1:0] gate_card_id;
    logic [NG-1:0]   gate_grant;
    logic [NG-1:0]   gate_resp_valid;
    logic            gate_card_active;
    logic            gate_fund_enough;
    logic            gate_timeout;
    logic            be_valid;
    logic [IDW-1:0]  be_card_id;
    logic            be_ready;
    logic            be_resp_valid;
    logic            be_card_active;
    logic            be_fund_enough;

    always #5 clk = ~clk;

    fare_backend_arbiter #(
        .NUM_GATES      (NG),
        .ID_W           (IDW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .gate_req         (gate_req),
        .gate_card_id     (gate_card_id),
        .gate_grant       (gate_grant),
        .gate_resp_valid  (gate_resp_valid),
        .gate_card_active (gate_card_active),
        .gate_fund_enough (gate_fund_enough),
        .gate_timeout     (gate_timeout),
        .be_valid         (be_valid),
        .be_card_id       (be_card_id),
        .be_ready         (be_ready),
        .be_resp_valid    (be_resp_valid),
        .be_card_active   (be_card_active),
        .be_fund_enough   (be_fund_enough)
    );

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [27:0] all_outs();
        return {gate_grant, gate_resp_valid, gate_card_active, gate_fund_enough,
                gate_timeout, be_valid, be_card_id};
    endfunction

    // Reference model: phase 0 idle, 1 request offered, 2 awaiting backend, 3 result out.
    int             m_phase = 0;
    int             m_owner = 0;
    int             m_ptr   = 0;
    int             m_wait  = 0;
    bit             m_mask_pend = 1'b0;
    int             m_mask_gate = 0;
    logic [IDW-1:0] m_id = '0;
    bit             m_act = 1'b0, m_fund = 1'b0, m_to = 1'b0;
    logic [NG-1:0]  m_eff;
    int             m_g;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_wait = 0; m_mask_pend = 1'b0;
            m_act = 1'b0; m_fund = 1'b0; m_to = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_eff = gate_req;
                    if (m_mask_pend) m_eff[m_mask_gate] = 1'b0;
                    m_mask_pend = 1'b0;
                    for (int k = 0; k < NG; k++) begin
                        m_g = (m_ptr + k) % NG;
                        if (m_eff[m_g]) begin
                            m_owner = m_g;
                            m_id    = gate_card_id[m_g*IDW +: IDW];
                            m_phase = 1;
                            break;
                        end
                    end
                end
                1: if (be_ready) begin m_phase = 2; m_wait = 0; end
                2: begin
                    m_wait++;
                    if (be_resp_valid) begin
                        m_act = be_card_active; m_fund = be_fund_enough; m_to = 1'b0; m_phase = 3;
                    end else if (m_wait == TO) begin
                        m_act = 1'b0; m_fund = 1'b0; m_to = 1'b1; m_phase = 3;
                    end
                end
                default: begin
                    m_phase = 0;
                    m_ptr = (m_owner + 1) % NG;
                    m_mask_pend = 1'b1;
                    m_mask_gate = m_owner;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_grant", gate_grant, (m_phase != 0) ? 4'(1 << m_owner) : 4'b0);
            chk("cyc_resp_valid", gate_resp_valid, (m_phase == 3) ? 4'(1 << m_owner) : 4'b0);
            chk("cyc_result", {gate_card_active, gate_fund_enough, gate_timeout},
                (m_phase == 3) ? {m_act, m_fund, m_to} : 3'b000);
            chk("cyc_be_valid", be_valid, m_phase == 1);
            chk("cyc_be_card_id", be_card_id, (m_phase == 1) ? m_id : 16'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int served[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int resp_cyc[$];
    int n;
    bit acc;

    initial begin
        rst = 1'b1; gate_req = '0;
        gate_card_id = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
        be_ready = 1'b1; be_resp_valid = 1'b0; be_card_active = 1'b0; be_fund_enough = 1'b0;
        step(); step();
        chk("reset_outputs", all_outs(), 28'h0);
        chk_en = 1'b1;
        rst = 1'b0;
        step();

        // Single request, minimum latency
        gate_req = 4'b0100;
        step();
        chk("t1_be_valid", be_valid, 1'b1);
        chk("t1_be_card_id", be_card_id, 16'hC222);
        chk("t1_grant", gate_grant, 4'b0100);
        step();
        be_resp_valid = 1'b1; be_card_active = 1'b1; be_fund_enough = 1'b1;
        step();
        chk("t1_resp_valid", gate_resp_valid, 4'b0100);
        chk("t1_result", {gate_card_active, gate_fund_enough, gate_timeout}, 3'b110);
        be_resp_valid = 1'b0; gate_req = '0;
        step(); step();

        // Fairness with all gates requesting, fresh pointer
        do_reset();
        gate_req = 4'b1111;
        for (int c = 0; c < 60 && served.size() < 5; c++) begin
            acc = be_valid && be_ready;
            step();
            be_resp_valid = acc; be_card_active = 1'b1; be_fund_enough = 1'b0;
            if (gate_resp_valid != 0) served.push_back($clog2(gate_resp_valid));
        end
        gate_req = '0; be_resp_valid = 1'b0;
        chk("t2_served_count", served.size(), 5);
        for (int i = 0; i < 5 && i < served.size(); i++) chk("t2_order", served[i], exp_order[i]);
        step(); step();

        // Timeout on gate 1
        gate_req = 4'b0010;
        step();
        chk("t3_grant", gate_grant, 4'b0010);
        n = 0;
        while (gate_resp_valid == 0 && n < 40) begin step(); n++; end
        chk("t3_latency", n, 16);
        chk("t3_resp_valid", gate_resp_valid, 4'b0010);
        chk("t3_result", {gate_card_active, gate_fund_enough, gate_timeout}, 3'b001);
        gate_req = '0;
        step(); step();

        // Response in the final wait cycle beats the timeout
        gate_req = 4'b1000;
        step();
        for (int k = 0; k < 15; k++) step();
        be_resp_valid = 1'b1; be_card_active = 1'b1; be_fund_enough = 1'b0;
        step();
        chk("t4_resp_valid", gate_resp_valid, 4'b1000);
        chk("t4_result", {gate_card_active, gate_fund_enough, gate_timeout}, 3'b100);
        be_resp_valid = 1'b0; gate_req = '0;
        step(); step();

        // Backpressure with the gate changing its card ID
        be_ready = 1'b0; gate_req = 4'b0001;
        step();
        for (int i = 0; i < 4; i++) begin
            gate_card_id[15:0] = 16'h5000 + 16'(i);
            step();
            chk("t5_hold_valid", be_valid, 1'b1);
            chk("t5_hold_id", be_card_id, 16'hA000);
        end
        be_ready = 1'b1; gate_card_id[15:0] = 16'h6666;
        step();
        chk("t5_after_hs", be_valid, 1'b0);
        be_resp_valid = 1'b1; be_card_active = 1'b0; be_fund_enough = 1'b1;
        step();
        chk("t5_resp_valid", gate_resp_valid, 4'b0001);
        chk("t5_result", {gate_card_active, gate_fund_enough, gate_timeout}, 3'b010);
        be_resp_valid = 1'b0; gate_req = '0; gate_card_id[15:0] = 16'hA000;
        step(); step();

        // Reset while waiting for the backend
        gate_req = 4'b0100;
        step(); step();
        rst = 1'b1;
        step();
        chk("t6_rst_outputs", all_outs(), 28'h0);
        rst = 1'b0; gate_req = '0;
        be_resp_valid = 1'b1; be_card_active = 1'b1; be_fund_enough = 1'b1;
        step();
        chk("t6_late_resp", all_outs(), 28'h0);
        be_resp_valid = 1'b0; gate_req = 4'b1001;
        step();
        chk("t6_ptr_zero", gate_grant, 4'b0001);
        step();
        be_resp_valid = 1'b1;
        step();
        chk("t6_resp_valid", gate_resp_valid, 4'b0001);
        be_resp_valid = 1'b0; gate_req = '0;
        step(); step();

        // Lone gate re-requesting sits out one IDLE cycle
        gate_req = 4'b0001;
        for (int c = 0; c < 40 && resp_cyc.size() < 2; c++) begin
            acc = be_valid && be_ready;
            step();
            be_resp_valid = acc;
            if (gate_resp_valid != 0) resp_cyc.push_back(c);
        end
        gate_req = '0; be_resp_valid = 1'b0;
        chk("t7_resp_count", resp_cyc.size(), 2);
        if (resp_cyc.size() == 2) chk("t7_spacing", resp_cyc[1] - resp_cyc[0], 5);
        step(); step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
